// File: rtl/rx_byte_fifo.sv
// Receive-side byte FIFO between a UART receiver and a byte consumer.
// Pops are registered (one-clock read latency); writes into a full FIFO are dropped and flagged.
module rx_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          R,
  input  logic [7:0]    rx_dat,
  input  logic          ok_rx_byte,
  input  logic          rd,
  input  logic          clr_ovf,
  output logic [7:0]    rd_dat,
  output logic          rd_vld,
  output logic          empty,
  output logic          full,
  output logic [AW:0]   cnt,
  output logic          ovf
);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rd_dat_q, rd_dat_d;
  logic          rd_vld_q, rd_vld_d;

  logic          rd_ok_s;
  logic          wr_ok_s;
  logic          drop_s;

  // Accept/drop decisions: a pop in the same cycle frees the slot a full write needs.
  always_comb begin
    rd_ok_s = rd & ~empty_q;
    wr_ok_s = ok_rx_byte & (~full_q | rd_ok_s);
    drop_s  = ok_rx_byte & ~wr_ok_s;
  end

  // Next-state for pointers, occupancy, flags and the read data register.
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    rd_dat_d = rd_dat_q;
    rd_vld_d = 1'b0;

    if (wr_ok_s) begin
      wp_d = wp_q + PTR_ONE;
    end else begin
      wp_d = wp_q;
    end

    if (rd_ok_s) begin
      rp_d     = rp_q + PTR_ONE;
      rd_dat_d = mem_q[rp_q];
      rd_vld_d = 1'b1;
    end else begin
      rp_d     = rp_q;
      rd_dat_d = rd_dat_q;
      rd_vld_d = 1'b0;
    end

    case ({wr_ok_s, rd_ok_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase

    // A drop in the same cycle as clr_ovf leaves the flag set.
    if (drop_s) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    empty_d = (cnt_d == {(AW+1){1'b0}});
    full_d  = (cnt_d == DEPTH_C);
  end

  // Control and status registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (R) begin
      wp_q     <= {AW{1'b0}};
      rp_q     <= {AW{1'b0}};
      cnt_q    <= {(AW+1){1'b0}};
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
      rd_dat_q <= 8'h00;
      rd_vld_q <= 1'b0;
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      rd_dat_q <= rd_dat_d;
      rd_vld_q <= rd_vld_d;
    end
  end

  // Byte storage; not cleared by reset, and reset blocks any write in its cycle.
  always_ff @(posedge clk) begin
    if (wr_ok_s && !R) begin
      mem_q[wp_q] <= rx_dat;
    end
  end

  assign rd_dat = rd_dat_q;
  assign rd_vld = rd_vld_q;
  assign empty  = empty_q;
  assign full   = full_q;
  assign cnt    = cnt_q;
  assign ovf    = ovf_q;

endmodule

// File: tb/tb_rx_byte_fifo.sv
// Self-checking bench for rx_byte_fifo: directed scenarios plus randomized traffic
// compared every cycle against a queue-based reference model.
module tb_rx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk;
  logic          R;
  logic [7:0]    rx_dat;
  logic          ok_rx_byte;
  logic          rd;
  logic          clr_ovf;
  logic [7:0]    rd_dat;
  logic          rd_vld;
  logic          empty;
  logic          full;
  logic [AW:0]   cnt;
  logic          ovf;

  int errs_r;
  int checks_r;

  // Reference model state
  logic [7:0] q_m[$];
  logic       ovf_m;
  logic [7:0] rd_dat_m;
  logic       rd_vld_m;

  rx_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk        (clk),
    .R          (R),
    .rx_dat     (rx_dat),
    .ok_rx_byte (ok_rx_byte),
    .rd         (rd),
    .clr_ovf    (clr_ovf),
    .rd_dat     (rd_dat),
    .rd_vld     (rd_vld),
    .empty      (empty),
    .full       (full),
    .cnt        (cnt),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_r++;
    if (got !== exp) begin
      errs_r++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".cnt"},    32'(cnt),    32'(q_m.size()));
    chk({tag, ".empty"},  32'(empty),  32'(q_m.size() == 0));
    chk({tag, ".full"},   32'(full),   32'(q_m.size() == DEPTH));
    chk({tag, ".ovf"},    32'(ovf),    32'(ovf_m));
    chk({tag, ".rd_vld"}, 32'(rd_vld), 32'(rd_vld_m));
    chk({tag, ".rd_dat"}, 32'(rd_dat), 32'(rd_dat_m));
  endtask

  // One clock: drive inputs, advance the model, clock the DUT, compare.
  task automatic step(input logic ok, input logic [7:0] d, input logic r_rd,
                      input logic clr, input logic rst, input string tag);
    logic rdok;
    logic wrok;
    ok_rx_byte = ok;
    rx_dat     = d;
    rd         = r_rd;
    clr_ovf    = clr;
    R          = rst;
    if (rst) begin
      q_m.delete();
      ovf_m    = 1'b0;
      rd_dat_m = 8'h00;
      rd_vld_m = 1'b0;
    end else begin
      rdok = r_rd && (q_m.size() > 0);
      wrok = ok && ((q_m.size() < DEPTH) || rdok);
      rd_vld_m = rdok;
      if (rdok) rd_dat_m = q_m.pop_front();
      if (wrok) q_m.push_back(d);
      if (clr) ovf_m = 1'b0;
      if (ok && !wrok) ovf_m = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic wr(input logic [7:0] d, input string tag);
    step(1'b1, d, 1'b0, 1'b0, 1'b0, tag);
  endtask

  task automatic pop(input string tag);
    step(1'b0, 8'($urandom), 1'b1, 1'b0, 1'b0, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    errs_r = 0;
    checks_r = 0;
    ovf_m = 1'b0;
    rd_dat_m = 8'h00;
    rd_vld_m = 1'b0;
    R = 1'b1;
    ok_rx_byte = 1'b0;
    rd = 1'b0;
    clr_ovf = 1'b0;
    rx_dat = 8'h00;

    // Reset, with other inputs active to show reset priority
    step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1, "rst0");
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, "rst1");

    // Two writes, two reads
    wr(8'hA5, "basic_w0");
    wr(8'h3C, "basic_w1");
    pop("basic_r0");
    chk("basic_a5", 32'(rd_dat), 32'h0000_00A5);
    pop("basic_r1");
    chk("basic_3c", 32'(rd_dat), 32'h0000_003C);
    idle("basic_end");
    chk("basic_vld_low", 32'(rd_vld), 32'h0);

    // Fill to full, overflow, drain
    for (int i = 0; i < DEPTH; i++) wr(8'(i), "fill");
    chk("fill_full", 32'(full), 32'h1);
    wr(8'hFF, "ovf_drop");
    chk("ovf_set", 32'(ovf), 32'h1);
    chk("ovf_cnt", 32'(cnt), 32'd16);
    for (int i = 0; i < DEPTH; i++) begin
      pop("drain");
      chk("drain_order", 32'(rd_dat), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'h1);

    // Read on empty is ignored; clear the overflow flag
    pop("rd_empty");
    chk("rd_empty_dat", 32'(rd_dat), 32'h0000_000F);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "clr_ovf");
    chk("ovf_cleared", 32'(ovf), 32'h0);

    // Full with simultaneous write and read
    for (int i = 0; i < DEPTH; i++) wr(8'(8'h80 + i), "fill2");
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0, "full_wr_rd");
    chk("full_wr_rd_cnt", 32'(cnt), 32'd16);
    chk("full_wr_rd_ovf", 32'(ovf), 32'h0);
    chk("full_wr_rd_dat", 32'(rd_dat), 32'h0000_0080);
    // Drop coincident with clear: set wins
    step(1'b1, 8'hEE, 1'b0, 1'b1, 1'b0, "drop_clr");
    chk("drop_clr_ovf", 32'(ovf), 32'h1);
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, "clr_again");
    for (int i = 0; i < DEPTH; i++) pop("drain2");
    chk("last_77", 32'(rd_dat), 32'h0000_0077);

    // 40 write/read pairs at low occupancy so pointers wrap
    wr(8'h01, "wrap_pre0");
    wr(8'h02, "wrap_pre1");
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0, "wrap");
      chk("wrap_nofull", 32'(full), 32'h0);
    end
    pop("wrap_d0");
    pop("wrap_d1");
    chk("wrap_last", 32'(rd_dat), 32'(8'h10 + 39));

    // Mid-operation reset discards contents
    for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i), "load5");
    step(1'b1, 8'h99, 1'b0, 1'b0, 1'b1, "mid_rst");
    chk("mid_rst_cnt", 32'(cnt), 32'h0);
    wr(8'h42, "post_rst_w");
    pop("post_rst_r");
    chk("post_rst_42", 32'(rd_dat), 32'h0000_0042);

    // Randomized traffic with alternating write-heavy and read-heavy phases
    for (int i = 0; i < 3000; i++) begin
      logic ph;
      ph = ((i / 80) % 2) == 0;
      step(($urandom_range(99) < (ph ? 80 : 30)),
           8'($urandom),
           ($urandom_range(99) < (ph ? 30 : 80)),
           ($urandom_range(99) < 5),
           ($urandom_range(999) < 3),
           "rand");
    end

    $display("Result: errors=%0d of %0d checks", errs_r, checks_r);
    $finish;
  end

endmodule

// File: doc/rx_byte_fifo.md
RX_BYTE_FIFO -- requirements
Module: rx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, 4..64.
REQ-002 Parameter AW, default 4, pointer width; SHALL equal log2(DEPTH).
REQ-003 clk  in  1  system clock; all state SHALL update on its rising edge only.
REQ-004 R  in  1  reset; synchronous, active-high.
REQ-005 rx_dat  in  8  received byte from the UART receiver shift register.
REQ-006 ok_rx_byte  in  1  byte-complete strobe from the receiver; each high cycle is one write request.
REQ-007 rd  in  1  read request from the consumer; each high cycle is one pop request.
REQ-008 clr_ovf  in  1  clears the sticky overflow flag.
REQ-009 rd_dat  out  8  registered byte popped by the last accepted read.
REQ-010 rd_vld  out  1  one-cycle pulse marking rd_dat as newly loaded.
REQ-011 empty  out  1  high when cnt = 0.
REQ-012 full  out  1  high when cnt = DEPTH.
REQ-013 cnt  out  AW+1  number of stored bytes, 0..DEPTH.
REQ-014 ovf  out  1  sticky flag: at least one byte was dropped.

Function
REQ-015 Storage SHALL be a DEPTH x 8 array with write pointer wp and read pointer rp, each AW bits, wrapping from DEPTH-1 to 0.
REQ-016 Write accepted (wr_ok) = ok_rx_byte & (!full | rd_ok); on wr_ok, mem[wp] <= rx_dat and wp <= wp+1.
REQ-017 Read accepted (rd_ok) = rd & !empty; on rd_ok, rd_dat <= mem[rp], rp <= rp+1, and rd_vld = 1 in the next cycle.
REQ-018 Read latency SHALL be exactly one clock: rd_ok in cycle n -> rd_dat and rd_vld valid in cycle n+1.
REQ-019 rd with empty = 1 SHALL be ignored: rd_dat holds, rd_vld stays 0, rp and cnt unchanged, no error flag.
REQ-020 cnt SHALL update as: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
REQ-021 Simultaneous wr_ok and rd_ok with cnt = 0 is impossible (rd_ok requires !empty); the write SHALL land normally and cnt becomes 1.
REQ-022 Simultaneous ok_rx_byte and rd when full: both SHALL be accepted, cnt stays DEPTH, ovf unchanged.
REQ-023 ok_rx_byte when full and no rd_ok: byte SHALL be dropped, memory/wp/cnt unchanged, ovf <= 1.
REQ-024 ovf SHALL stay 1 until clr_ovf or R; if clr_ovf and a new drop coincide, ovf SHALL end the cycle at 1 (set wins).
REQ-025 A byte written in cycle n SHALL be readable (rd_ok possible) from cycle n+1; empty deasserts in cycle n+1.
REQ-026 ok_rx_byte held high for k cycles SHALL be treated as k write requests; no edge detection is performed.
REQ-027 empty, full and cnt SHALL be registered or derived from registered cnt only; no combinational path from inputs.
REQ-028 rx_dat SHALL be sampled only in the cycle of wr_ok; its value at other times is don't-care.

Reset
REQ-029 While R = 1: wp = 0, rp = 0, cnt = 0, empty = 1, full = 0, ovf = 0, rd_vld = 0, rd_dat = 8'h00.
REQ-030 R SHALL take priority over ok_rx_byte, rd and clr_ovf in the same cycle; memory contents need not be cleared.
REQ-031 R asserted mid-operation SHALL discard all stored bytes; the first write after R deasserts lands at address 0.

Verification
REQ-032 After R, write 8'hA5 then 8'h3C, then one-cycle rd, one-cycle rd -> rd_dat = A5 then 3C, each with a one-cycle rd_vld pulse; empty = 1 and cnt = 0 at end.
REQ-033 Write DEPTH bytes 0x00..0x0F -> full = 1, cnt = 16; 17th write 0xFF -> ovf = 1, cnt = 16; draining 16 reads returns 0x00..0x0F, and 0xFF is never returned.
REQ-034 With full = 1, assert ok_rx_byte (rx_dat = 0x77) and rd in the same cycle -> cnt stays 16, ovf stays 0, rd_dat = oldest byte, and 0x77 is the last byte returned after the full drain.
REQ-035 Perform 40 write/read pairs at cnt 1..3 so that wp and rp wrap twice -> data order is preserved, and full never asserts.
REQ-036 rd on empty FIFO -> rd_vld = 0 and rd_dat unchanged; with ovf = 1, pulse clr_ovf -> ovf = 0 next cycle; clr_ovf coincident with a drop -> ovf = 1.
REQ-037 Load 5 bytes, assert R for one cycle with ok_rx_byte = 1 -> cnt = 0, empty = 1, ovf = 0; the next write of 0x42 followed by rd returns 0x42.
